// File: rtl/sd_sector_seq_if.sv
// Bundle between the image sequencer and its requester/SD-controller side.
// Request, start, done and abort lines are single-cycle pulses; the controller busy lines are level handshakes.
interface sd_sector_seq_if #(
    parameter int DW     = 16,
    parameter int SLOT_W = 2,
    parameter int LEN_W  = 10
);
    logic              sd_init_done;
    logic              save_req;
    logic              read_req;
    logic [SLOT_W-1:0] slot_sel;
    logic              test_mode;
    logic              abort;
    logic [LEN_W-1:0]  fifo_len;
    logic              wr_req;
    logic              wr_busy;
    logic              rd_busy;
    logic              rd_val_en;
    logic              wr_start_en;
    logic              rd_start_en;
    logic [31:0]       sec_addr;
    logic [DW-1:0]     pat_data;
    logic              data_sel;
    logic              wr_done;
    logic              rd_done;
    logic              abort_done;
    logic              rd_len_err;
    logic              busy;
    logic [2:0]        state;

    modport master (
        output sd_init_done, save_req, read_req, slot_sel, test_mode, abort,
               fifo_len, wr_req, wr_busy, rd_busy, rd_val_en,
        input  wr_start_en, rd_start_en, sec_addr, pat_data, data_sel,
               wr_done, rd_done, abort_done, rd_len_err, busy, state
    );

    modport slave (
        input  sd_init_done, save_req, read_req, slot_sel, test_mode, abort,
               fifo_len, wr_req, wr_busy, rd_busy, rd_val_en,
        output wr_start_en, rd_start_en, sec_addr, pat_data, data_sel,
               wr_done, rd_done, abort_done, rd_len_err, busy, state
    );
endinterface

// File: rtl/sd_sector_seq.sv
// Sequences whole-image saves and reads on an SD card, one sector at a time,
// with per-sector read length checking and sector-granular abort.
module sd_sector_seq #(
    parameter int          DW          = 16,
    parameter int          SEC_WORDS   = 256,
    parameter int          IMG_SECTORS = 1200,
    parameter int          SLOTS       = 4,
    parameter int          SLOT_W      = 2,
    parameter logic [31:0] BASE_SEC    = 32'd16384,
    parameter int          LEN_W       = 10
) (
    input logic          clk,
    input logic          rst,
    sd_sector_seq_if.slave sd
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        WR_START  = 3'd2,
        WR_BUSY   = 3'd3,
        RD_START  = 3'd4,
        RD_BUSY   = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              test_q, test_d;
    logic [31:0]       sec_cnt_q, sec_cnt_d;
    logic [31:0]       sec_addr_q, sec_addr_d;
    logic [DW-1:0]     pat_q, pat_d;
    logic              seen_q, seen_d;
    logic [31:0]       rd_cnt_q, rd_cnt_d;
    logic              len_err_q, len_err_d;
    logic              abort_pend_q, abort_pend_d;
    logic              abort_done_q, abort_done_d;
    logic              wr_start, rd_start;
    logic [31:0]       rd_cnt_nx;
    logic              slot_ok, last_sec, stop;

    function automatic logic [31:0] addr_of(input logic [SLOT_W-1:0] s, input logic [31:0] c);
        return BASE_SEC + 32'(s) * 32'(IMG_SECTORS) + c;
    endfunction

    // Slot indices beyond the card layout are refused rather than aliased.
    assign slot_ok  = 32'(sd.slot_sel) < SLOTS;
    assign last_sec = (sec_cnt_q + 32'd1) == 32'(IMG_SECTORS);
    assign stop     = sd.abort || abort_pend_q;

    always_comb begin
        state_d      = state_q;
        op_wr_d      = op_wr_q;
        slot_d       = slot_q;
        test_d       = test_q;
        sec_cnt_d    = sec_cnt_q;
        sec_addr_d   = sec_addr_q;
        pat_d        = pat_q;
        seen_d       = seen_q;
        rd_cnt_d     = rd_cnt_q;
        len_err_d    = len_err_q;
        abort_done_d = 1'b0;
        wr_start     = 1'b0;
        rd_start     = 1'b0;
        rd_cnt_nx    = rd_cnt_q + 32'(sd.rd_val_en);
        case (state_q)
            IDLE: begin
                if (sd.sd_init_done && slot_ok && (sd.save_req || sd.read_req)) begin
                    op_wr_d    = sd.save_req;
                    slot_d     = sd.slot_sel;
                    test_d     = sd.test_mode;
                    sec_cnt_d  = 32'd0;
                    pat_d      = '0;
                    sec_addr_d = addr_of(sd.slot_sel, 32'd0);
                    state_d    = sd.save_req ? WAIT_DATA : RD_START;
                end
            end
            WAIT_DATA: begin
                if (sd.abort) begin
                    state_d      = IDLE;
                    abort_done_d = 1'b1;
                end else if (test_q || 32'(sd.fifo_len) >= 32'(SEC_WORDS)) begin
                    state_d = WR_START;
                end
            end
            WR_START: begin
                if (sd.abort) begin
                    state_d      = IDLE;
                    abort_done_d = 1'b1;
                end else begin
                    wr_start = 1'b1;
                    seen_d   = 1'b0;
                    state_d  = WR_BUSY;
                end
            end
            WR_BUSY: begin
                if (sd.wr_req) pat_d = pat_q + {{(DW-1){1'b0}}, 1'b1};
                if (sd.wr_busy) seen_d = 1'b1;
                if (seen_q && !sd.wr_busy) begin
                    sec_cnt_d  = sec_cnt_q + 32'd1;
                    sec_addr_d = addr_of(slot_q, sec_cnt_q + 32'd1);
                    if (stop) begin
                        state_d      = IDLE;
                        abort_done_d = 1'b1;
                    end else begin
                        state_d = last_sec ? DONE : WAIT_DATA;
                    end
                end
            end
            RD_START: begin
                if (sd.abort) begin
                    state_d      = IDLE;
                    abort_done_d = 1'b1;
                end else begin
                    rd_start = 1'b1;
                    seen_d   = 1'b0;
                    rd_cnt_d = 32'd0;
                    state_d  = RD_BUSY;
                end
            end
            RD_BUSY: begin
                rd_cnt_d = rd_cnt_nx;
                if (sd.rd_busy) seen_d = 1'b1;
                if (seen_q && !sd.rd_busy) begin
                    if (rd_cnt_nx != 32'(SEC_WORDS)) len_err_d = 1'b1;
                    sec_cnt_d  = sec_cnt_q + 32'd1;
                    sec_addr_d = addr_of(slot_q, sec_cnt_q + 32'd1);
                    if (stop) begin
                        state_d      = IDLE;
                        abort_done_d = 1'b1;
                    end else begin
                        state_d = last_sec ? DONE : RD_START;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Pending abort lives only while an operation is in flight.
        abort_pend_d = abort_pend_q || (sd.abort && state_q != IDLE);
        if (state_d == IDLE) abort_pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_wr_q      <= 1'b0;
            slot_q       <= '0;
            test_q       <= 1'b0;
            sec_cnt_q    <= 32'd0;
            sec_addr_q   <= 32'd0;
            pat_q        <= '0;
            seen_q       <= 1'b0;
            rd_cnt_q     <= 32'd0;
            len_err_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            abort_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_wr_q      <= op_wr_d;
            slot_q       <= slot_d;
            test_q       <= test_d;
            sec_cnt_q    <= sec_cnt_d;
            sec_addr_q   <= sec_addr_d;
            pat_q        <= pat_d;
            seen_q       <= seen_d;
            rd_cnt_q     <= rd_cnt_d;
            len_err_q    <= len_err_d;
            abort_pend_q <= abort_pend_d;
            abort_done_q <= abort_done_d;
        end
    end

    assign sd.wr_start_en = wr_start;
    assign sd.rd_start_en = rd_start;
    assign sd.sec_addr    = sec_addr_q;
    assign sd.pat_data    = pat_q;
    assign sd.data_sel    = (state_q != IDLE) && op_wr_q && !test_q;
    assign sd.wr_done     = (state_q == DONE) && op_wr_q;
    assign sd.rd_done     = (state_q == DONE) && !op_wr_q;
    assign sd.abort_done  = abort_done_q;
    assign sd.rd_len_err  = len_err_q;
    assign sd.busy        = state_q != IDLE;
    assign sd.state       = state_q;
endmodule

// File: tb/tb_sd_sector_seq.sv
// Directed bench for sd_sector_seq: expected pulse events are queued by the
// stimulus and matched by an independent monitor; state checks are inline.
module tb_sd_sector_seq;
    localparam int          IMG  = 3;
    localparam logic [31:0] BASE = 32'd16384;
    localparam int          EW   = 35;
    localparam logic [2:0]  EV_W = 3'd1, EV_R = 3'd2, EV_WD = 3'd3, EV_RD = 3'd4, EV_AB = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks_total = 0;
    int   checks_passed = 0;
    logic [EW-1:0] exp_q[$];

    sd_sector_seq_if #(.DW(16), .SLOT_W(2), .LEN_W(10)) bus ();

    sd_sector_seq #(.IMG_SECTORS(IMG)) dut (
        .clk(clk),
        .rst(rst),
        .sd (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] ev(input logic [2:0] k, input logic [31:0] a);
        return {k, a};
    endfunction

    function automatic logic [31:0] sa(input int slot, input int sec);
        return BASE + 32'(slot * IMG + sec);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic sb_check(input string name, input logic [EW-1:0] got);
        logic [EW-1:0] e;
        checks_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: unexpected event kind %0d addr %0d", name, got[34:32], got[31:0]);
        end else begin
            e = exp_q.pop_front();
            if (got === e) checks_passed++;
            else $display("FAIL %s: got kind %0d addr %0d expected kind %0d addr %0d",
                          name, got[34:32], got[31:0], e[34:32], e[31:0]);
        end
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_start_en) sb_check("wr_start", ev(EV_W, bus.sec_addr));
            if (bus.rd_start_en) sb_check("rd_start", ev(EV_R, bus.sec_addr));
            if (bus.wr_done)     sb_check("wr_done", ev(EV_WD, 32'd0));
            if (bus.rd_done)     sb_check("rd_done", ev(EV_RD, 32'd0));
            if (bus.abort_done)  sb_check("abort_done", ev(EV_AB, 32'd0));
        end
    end

    task automatic start_op(input bit sv, input bit rd, input int slot, input bit tm);
        @(posedge clk); #1;
        bus.save_req = sv; bus.read_req = rd;
        bus.slot_sel = 2'(slot); bus.test_mode = tm;
        @(posedge clk); #1;
        bus.save_req = 1'b0; bus.read_req = 1'b0;
    endtask

    task automatic wait_start(input bit rd, output int n);
        int k;
        for (k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (rd ? bus.rd_start_en : bus.wr_start_en) break;
        end
        n = k;
        if (k > 64) begin
            checks_total++;
            $display("FAIL start_timeout: got none after %0d cycles, required a start pulse", k - 1);
        end
    endtask

    task automatic run_wr_sector(input int n_req, input bit ab_mid, input bit ab_fall, output int waited);
        wait_start(1'b0, waited);
        @(posedge clk); #1;
        bus.wr_busy = 1'b1; bus.wr_req = 1'b1; bus.abort = ab_mid;
        for (int i = 0; i < n_req; i++) begin
            @(posedge clk); #1;
            bus.abort = 1'b0;
        end
        bus.wr_req = 1'b0; bus.wr_busy = 1'b0; bus.abort = ab_fall;
        @(posedge clk); #1;
        bus.abort = 1'b0;
    endtask

    task automatic run_rd_sector(input int n_val);
        int w;
        wait_start(1'b1, w);
        @(posedge clk); #1;
        bus.rd_busy = 1'b1; bus.rd_val_en = 1'b1;
        repeat (n_val) @(posedge clk);
        #1;
        bus.rd_val_en = 1'b0; bus.rd_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        bus.sd_init_done = 1'b0; bus.save_req = 1'b0; bus.read_req = 1'b0;
        bus.slot_sel = '0; bus.test_mode = 1'b0; bus.abort = 1'b0;
        bus.fifo_len = '0; bus.wr_req = 1'b0; bus.wr_busy = 1'b0;
        bus.rd_busy = 1'b0; bus.rd_val_en = 1'b0;

        // Reset values
        #12;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sec_addr", bus.sec_addr, 0);
        chk("rst_pat", 32'(bus.pat_data), 0);
        chk("rst_data_sel", 32'(bus.data_sel), 0);
        chk("rst_len_err", 32'(bus.rd_len_err), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Requests before init are ignored
        start_op(1'b1, 1'b0, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("preinit_state", 32'(bus.state), 0);
        bus.sd_init_done = 1'b1;

        // Abort while idle does nothing
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("idle_abort_state", 32'(bus.state), 0);

        // Test-mode save, slot 2, full sectors of 256 consume strobes
        for (int s = 0; s < IMG; s++) exp_q.push_back(ev(EV_W, sa(2, s)));
        exp_q.push_back(ev(EV_WD, 0));
        start_op(1'b1, 1'b0, 2, 1'b1);
        chk("save_state_wait", 32'(bus.state), 1);
        chk("save_busy", 32'(bus.busy), 1);
        chk("save_tm_data_sel", 32'(bus.data_sel), 0);
        for (int s = 0; s < IMG; s++) run_wr_sector(256, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;
        chk("save_pat_768", 32'(bus.pat_data), 768);
        chk("save_end_state", 32'(bus.state), 0);

        // FIFO-gated save: 255 holds, 256 starts on the next cycle
        bus.fifo_len = 10'd255;
        start_op(1'b1, 1'b0, 1, 1'b0);
        chk("fifo_pat_cleared", 32'(bus.pat_data), 0);
        chk("fifo_data_sel", 32'(bus.data_sel), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("fifo_hold_state", 32'(bus.state), 1);
        for (int s = 0; s < IMG; s++) exp_q.push_back(ev(EV_W, sa(1, s)));
        exp_q.push_back(ev(EV_WD, 0));
        bus.fifo_len = 10'd256;
        run_wr_sector(10, 1'b0, 1'b0, w);
        chk("fifo_start_latency", 32'(w), 2);
        for (int s = 1; s < IMG; s++) run_wr_sector(10, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1 chk("fifo_pat_30", 32'(bus.pat_data), 30);
        bus.fifo_len = '0;

        // Save and read together: save wins
        for (int s = 0; s < IMG; s++) exp_q.push_back(ev(EV_W, sa(0, s)));
        exp_q.push_back(ev(EV_WD, 0));
        start_op(1'b1, 1'b1, 0, 1'b1);
        for (int s = 0; s < IMG; s++) run_wr_sector(4, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1 chk("both_pat_12", 32'(bus.pat_data), 12);

        // Read with a short second sector
        for (int s = 0; s < IMG; s++) exp_q.push_back(ev(EV_R, sa(3, s)));
        exp_q.push_back(ev(EV_RD, 0));
        start_op(1'b0, 1'b1, 3, 1'b0);
        chk("read_data_sel", 32'(bus.data_sel), 0);
        run_rd_sector(256);
        chk("read_len_ok", 32'(bus.rd_len_err), 0);
        run_rd_sector(255);
        chk("read_len_err", 32'(bus.rd_len_err), 1);
        run_rd_sector(256);
        repeat (3) @(posedge clk);
        #1;
        chk("read_len_sticky", 32'(bus.rd_len_err), 1);
        chk("read_end_state", 32'(bus.state), 0);

        // Abort mid second write sector: sector finishes, no wr_done
        exp_q.push_back(ev(EV_W, sa(1, 0)));
        exp_q.push_back(ev(EV_W, sa(1, 1)));
        exp_q.push_back(ev(EV_AB, 0));
        start_op(1'b1, 1'b0, 1, 1'b1);
        run_wr_sector(8, 1'b0, 1'b0, w);
        run_wr_sector(8, 1'b1, 1'b0, w);
        chk("abort_mid_state", 32'(bus.state), 0);
        chk("abort_mid_pat", 32'(bus.pat_data), 16);
        repeat (4) @(posedge clk);

        // Abort on the final busy fall: abort_done only
        for (int s = 0; s < IMG; s++) exp_q.push_back(ev(EV_W, sa(3, s)));
        exp_q.push_back(ev(EV_AB, 0));
        start_op(1'b1, 1'b0, 3, 1'b1);
        run_wr_sector(8, 1'b0, 1'b0, w);
        run_wr_sector(8, 1'b0, 1'b0, w);
        run_wr_sector(8, 1'b0, 1'b1, w);
        chk("abort_fall_state", 32'(bus.state), 0);
        repeat (4) @(posedge clk);

        // Abort while waiting for FIFO data returns at once
        exp_q.push_back(ev(EV_AB, 0));
        start_op(1'b1, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        chk("abort_wait_state", 32'(bus.state), 0);
        repeat (3) @(posedge clk);

        // Reset mid read, then a clean restart from sector 0
        exp_q.push_back(ev(EV_R, sa(1, 0)));
        start_op(1'b0, 1'b1, 1, 1'b0);
        wait_start(1'b1, w);
        @(posedge clk); #1;
        bus.rd_busy = 1'b1; bus.rd_val_en = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("pre_rst_state", 32'(bus.state), 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(bus.state), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_addr", bus.sec_addr, 0);
        chk("mid_rst_len_err", 32'(bus.rd_len_err), 0);
        bus.rd_busy = 1'b0; bus.rd_val_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int s = 0; s < IMG; s++) exp_q.push_back(ev(EV_R, sa(1, s)));
        exp_q.push_back(ev(EV_RD, 0));
        start_op(1'b0, 1'b1, 1, 1'b0);
        for (int s = 0; s < IMG; s++) run_rd_sector(256);
        repeat (4) @(posedge clk);
        #1;
        chk("restart_len_err", 32'(bus.rd_len_err), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
